// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: multi-byte instruction register with a PC-driven fetch sequencer.
// On start it reads INSTR_BYTES consecutive bytes from a combinational-read
// byte memory at PC and packs them little-endian into the IR, advancing PC
// once per byte, then pulses done for one cycle.
// Optional build macro IR_FETCH_ABORT_EN adds an abort input that cancels a
// fetch in progress and an aborted output that pulses one cycle afterwards.
module ir_fetch_unit #(
  parameter  int DATA_W      = 8,
  parameter  int ADDR_W      = 8,
  parameter  int INSTR_BYTES = 2,
  localparam int SEL_W       = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1,
  localparam int IR_W        = DATA_W * INSTR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              ir_en,
  input  logic [1:0]        ir_funsel,
  input  logic [SEL_W-1:0]  ir_byte_sel,
  input  logic [DATA_W-1:0] ir_load_val,
  input  logic [DATA_W-1:0] mem_data,
`ifdef IR_FETCH_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [IR_W-1:0]   ir_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [IR_W-1:0]   ir;
  logic [SEL_W-1:0]  cnt;
  logic              last_byte;
  logic              abort_hit;

  // Program counter advance; wraps from all-ones back to zero.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] p);
    return p + ADDR_W'(1);
  endfunction

  // Whole-IR increment, modulo 2^IR_W.
  function automatic logic [IR_W-1:0] ir_wrap_inc(input logic [IR_W-1:0] v);
    return v + IR_W'(1);
  endfunction

  // Whole-IR decrement, modulo 2^IR_W.
  function automatic logic [IR_W-1:0] ir_wrap_dec(input logic [IR_W-1:0] v);
    return v - IR_W'(1);
  endfunction

  // Replace one byte slot; a selector beyond the last slot matches nothing,
  // so the IR is returned unchanged.
  function automatic logic [IR_W-1:0] ir_put_slot(input logic [IR_W-1:0]   v,
                                                  input logic [SEL_W-1:0]  sel,
                                                  input logic [DATA_W-1:0] b);
    logic [IR_W-1:0] r;
    r = v;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      if (sel == SEL_W'(k)) begin
        r[k*DATA_W +: DATA_W] = b;
      end
    end
    return r;
  endfunction

  // Direct IR operation selected by ir_funsel.
  function automatic logic [IR_W-1:0] ir_apply_op(input logic [IR_W-1:0]   v,
                                                  input logic [1:0]        fsel,
                                                  input logic [SEL_W-1:0]  sel,
                                                  input logic [DATA_W-1:0] b);
    logic [IR_W-1:0] r;
    case (fsel)
      2'b00:   r = '0;
      2'b01:   r = ir_put_slot(v, sel, b);
      2'b10:   r = ir_wrap_dec(v);
      default: r = ir_wrap_inc(v);
    endcase
    return r;
  endfunction

  assign last_byte = (cnt == SEL_W'(INSTR_BYTES - 1));

`ifdef IR_FETCH_ABORT_EN
  assign abort_hit = (state == READ) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt = state;
    mem_cs    = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        mem_cs = 1'b0;
        busy   = 1'b1;
        if (abort_hit) begin
          state_nxt = IDLE;
        end else if (last_byte) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC, IR and byte counter: IDLE-side direct operations and READ-side capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      ir  <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end
          if (ir_en) begin
            ir <= ir_apply_op(ir, ir_funsel, ir_byte_sel, ir_load_val);
          end
          if (start) begin
            cnt <= '0;
          end
        end
        READ: begin
          if (!abort_hit) begin
            ir  <= ir_put_slot(ir, cnt, mem_data);
            pc  <= pc_advance(pc);
            cnt <= cnt + SEL_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IR_FETCH_ABORT_EN
  // One-cycle pulse in the cycle following an accepted abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

  assign mem_addr = pc;
  assign pc_out   = pc;
  assign ir_out   = ir;
  assign mem_wr   = 1'b0;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: a 2-byte and a 3-byte instance share one stimulus
// stream and one byte memory image; a timeline model predicts every output.
module tb_ir_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic        ir_en;
  logic [1:0]  ir_funsel;
  logic [1:0]  ir_byte_sel;
  logic [7:0]  ir_load_val;
`ifdef IR_FETCH_ABORT_EN
  logic        abort;
  logic        aborted_a;
  logic        aborted_b;
  bit          exp_ab [2];
  bit          nxt_ab;
`endif

  logic [7:0]  mem [256];

  logic [7:0]  mem_data_a, mem_addr_a, pc_a;
  logic        cs_a, wr_a, busy_a, done_a;
  logic [15:0] ir_a;
  logic [7:0]  mem_data_b, mem_addr_b, pc_b;
  logic        cs_b, wr_b, busy_b, done_b;
  logic [23:0] ir_b;

  assign mem_data_a = mem[mem_addr_a];
  assign mem_data_b = mem[mem_addr_b];

  ir_fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .ir_en(ir_en), .ir_funsel(ir_funsel), .ir_byte_sel(ir_byte_sel[0:0]),
    .ir_load_val(ir_load_val), .mem_data(mem_data_a),
`ifdef IR_FETCH_ABORT_EN
    .abort(abort), .aborted(aborted_a),
`endif
    .mem_addr(mem_addr_a), .mem_cs(cs_a), .mem_wr(wr_a), .pc_out(pc_a),
    .ir_out(ir_a), .busy(busy_a), .done(done_a)
  );

  ir_fetch_unit #(.DATA_W(8), .ADDR_W(8), .INSTR_BYTES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .ir_en(ir_en), .ir_funsel(ir_funsel), .ir_byte_sel(ir_byte_sel),
    .ir_load_val(ir_load_val), .mem_data(mem_data_b),
`ifdef IR_FETCH_ABORT_EN
    .abort(abort), .aborted(aborted_b),
`endif
    .mem_addr(mem_addr_b), .mem_cs(cs_b), .mem_wr(wr_b), .pc_out(pc_b),
    .ir_out(ir_b), .busy(busy_b), .done(done_b)
  );

  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: committed IDLE state plus, while a fetch is running, the cycle
  // index of its first READ cycle, its base address and the IR it started from.
  int          nb [2];
  logic [63:0] m_ir [2];
  logic [7:0]  m_pc [2];
  bit          in_fetch [2];
  int          t_start [2];
  logic [7:0]  f_base [2];
  logic [63:0] f_ir [2];
  bit          m_valid;
  int          cyc;
  int          jj;
  int          s;
  logic [63:0] e_ir, a_ir;
  logic [7:0]  e_pc, a_pc, a_addr;
  logic        e_busy, e_done, e_cs, a_busy, a_done, a_cs, a_wr;

  // IR seen j cycles after the fetch began: slots below j hold memory bytes.
  function automatic logic [63:0] ir_at(input int c, input int j);
    logic [63:0] v;
    v = f_ir[c];
    for (int i = 0; i < nb[c]; i++) begin
      if (i < j) v[i*8 +: 8] = mem[8'(f_base[c] + 8'(i))];
    end
    return v;
  endfunction

  function automatic logic [63:0] mask_of(input int c);
    return (64'd1 << (8 * nb[c])) - 64'd1;
  endfunction

  // Compare every output each cycle, then advance the model for the next edge.
  initial begin
    nb[0] = 2; nb[1] = 3;
    m_valid = 0;
    cyc = 0;
    for (int c = 0; c < 2; c++) begin
      in_fetch[c] = 0; m_ir[c] = '0; m_pc[c] = '0;
`ifdef IR_FETCH_ABORT_EN
      exp_ab[c] = 0;
`endif
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (in_fetch[c]) begin
          jj     = cyc - t_start[c];
          e_ir   = ir_at(c, jj);
          e_pc   = f_base[c] + 8'((jj < nb[c]) ? jj : nb[c]);
          e_busy = 1'b1;
          e_done = (jj == nb[c]);
          e_cs   = (jj >= nb[c]);
        end else begin
          e_ir = m_ir[c]; e_pc = m_pc[c];
          e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1;
        end
        if (c == 0) begin
          a_ir = {48'd0, ir_a}; a_pc = pc_a; a_addr = mem_addr_a;
          a_cs = cs_a; a_wr = wr_a; a_busy = busy_a; a_done = done_a;
        end else begin
          a_ir = {40'd0, ir_b}; a_pc = pc_b; a_addr = mem_addr_b;
          a_cs = cs_b; a_wr = wr_b; a_busy = busy_b; a_done = done_b;
        end
        if (m_valid) begin
          chk($sformatf("c%0d_ir@%0d", c, cyc), a_ir, e_ir);
          chk($sformatf("c%0d_pc@%0d", c, cyc), 64'(a_pc), 64'(e_pc));
          chk($sformatf("c%0d_addr@%0d", c, cyc), 64'(a_addr), 64'(e_pc));
          chk($sformatf("c%0d_cs@%0d", c, cyc), 64'(a_cs), 64'(e_cs));
          chk($sformatf("c%0d_wr@%0d", c, cyc), 64'(a_wr), 64'd0);
          chk($sformatf("c%0d_busy@%0d", c, cyc), 64'(a_busy), 64'(e_busy));
          chk($sformatf("c%0d_done@%0d", c, cyc), 64'(a_done), 64'(e_done));
`ifdef IR_FETCH_ABORT_EN
          chk($sformatf("c%0d_aborted@%0d", c, cyc),
              64'((c == 0) ? aborted_a : aborted_b), 64'(exp_ab[c]));
`endif
        end
`ifdef IR_FETCH_ABORT_EN
        nxt_ab = 0;
`endif
        if (rst) begin
          in_fetch[c] = 0; m_ir[c] = '0; m_pc[c] = '0;
        end else if (m_valid) begin
          if (in_fetch[c]) begin
            jj = cyc - t_start[c];
`ifdef IR_FETCH_ABORT_EN
            if (abort && jj < nb[c]) begin
              m_ir[c] = ir_at(c, jj);
              m_pc[c] = f_base[c] + 8'(jj);
              in_fetch[c] = 0;
              nxt_ab = 1;
            end
`endif
            if (in_fetch[c] && jj == nb[c]) begin
              m_ir[c] = ir_at(c, jj);
              m_pc[c] = f_base[c] + 8'(nb[c]);
              in_fetch[c] = 0;
            end
          end else begin
            if (pc_load) m_pc[c] = pc_load_val;
            if (ir_en) begin
              case (ir_funsel)
                2'b00: m_ir[c] = '0;
                2'b01: begin
                  s = (c == 0) ? int'(ir_byte_sel[0]) : int'(ir_byte_sel);
                  if (s < nb[c]) m_ir[c][s*8 +: 8] = ir_load_val;
                end
                2'b10: m_ir[c] = (m_ir[c] - 64'd1) & mask_of(c);
                default: m_ir[c] = (m_ir[c] + 64'd1) & mask_of(c);
              endcase
            end
            if (start) begin
              in_fetch[c] = 1;
              t_start[c]  = cyc + 1;
              f_base[c]   = m_pc[c];
              f_ir[c]     = m_ir[c];
            end
          end
        end
`ifdef IR_FETCH_ABORT_EN
        exp_ab[c] = nxt_ab;
`endif
      end
      if (rst) m_valid = 1;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ir_op(input logic [1:0] f, input logic [1:0] sel, input logic [7:0] v);
    ir_en = 1'b1; ir_funsel = f; ir_byte_sel = sel; ir_load_val = v;
    tick();
    ir_en = 1'b0;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; pc_load = 1'b0; pc_load_val = '0;
    ir_en = 1'b0; ir_funsel = '0; ir_byte_sel = '0; ir_load_val = '0;
`ifdef IR_FETCH_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'h5A;
    mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22; mem[8'h01] = 8'h33;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03;

    tick(); tick();
    rst = 1'b0;
    chk("rst_ir", 64'(ir_a), 64'h0);
    chk("rst_pc", 64'(pc_a), 64'h0);
    chk("rst_cs", 64'(cs_a), 64'h1);
    chk("rst_busy", 64'(busy_a), 64'h0);

    // Basic 2-byte fetch from 0x10.
    pc_load = 1'b1; pc_load_val = 8'h10; tick(); pc_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("f1_addr0", 64'(mem_addr_a), 64'h10);
    chk("f1_cs0", 64'(cs_a), 64'h0);
    tick();
    chk("f1_addr1", 64'(mem_addr_a), 64'h11);
    chk("f1_done_early", 64'(done_a), 64'h0);
    tick();
    chk("f1_done", 64'(done_a), 64'h1);
    chk("f1_busy", 64'(busy_a), 64'h1);
    tick();
    chk("f1_ir", 64'(ir_a), 64'h3CA5);
    chk("f1_pc", 64'(pc_a), 64'h12);
    chk("f1_idle", 64'(busy_a), 64'h0);
    chk("f1b_done", 64'(done_b), 64'h1);
    chk("f1b_ir", 64'(ir_b), 64'h5A3CA5);
    tick();

    // PC wrap across 0xFF.
    pc_load = 1'b1; pc_load_val = 8'hFF; tick(); pc_load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("wrap_ir", 64'(ir_a), 64'h2211);
    chk("wrap_pc", 64'(pc_a), 64'h01);
    tick();
    chk("wrapb_ir", 64'(ir_b), 64'h332211);
    chk("wrapb_pc", 64'(pc_b), 64'h02);

    // Direct IR operations in IDLE.
    ir_op(2'b00, 2'd0, 8'h00);
    chk("op_clear", 64'(ir_a), 64'h0000);
    ir_op(2'b01, 2'd1, 8'h80);
    chk("op_load1", 64'(ir_a), 64'h8000);
    ir_op(2'b00, 2'd0, 8'h00);
    ir_op(2'b01, 2'd0, 8'hFF);
    ir_op(2'b11, 2'd0, 8'h00);
    chk("op_inc", 64'(ir_a), 64'h0100);
    ir_op(2'b00, 2'd0, 8'h00);
    ir_op(2'b10, 2'd0, 8'h00);
    chk("op_dec", 64'(ir_a), 64'hFFFF);
    chk("op_decb", 64'(ir_b), 64'hFFFFFF);
    ir_op(2'b01, 2'd3, 8'h5E);
    chk("op_sel3", 64'(ir_a), 64'h5EFF);
    chk("op_sel3b", 64'(ir_b), 64'hFFFFFF);

    // Fetch from 0x01 with ops, pc_load and start all held while busy.
    start = 1'b1; tick();
    ir_en = 1'b1; ir_funsel = 2'b00; pc_load = 1'b1; pc_load_val = 8'h40;
    tick(); tick(); tick();
    ir_en = 1'b0; pc_load = 1'b0; start = 1'b0;
    chk("busy_ign_ir", 64'(ir_a), 64'h1133);
    chk("busy_ign_pc", 64'(pc_a), 64'h03);
    tick(); tick();

    // Reset in the second READ cycle.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rmid_ir", 64'(ir_a), 64'h0);
    chk("rmid_pc", 64'(pc_a), 64'h0);
    chk("rmid_cs", 64'(cs_a), 64'h1);
    chk("rmid_busy", 64'(busy_b), 64'h0);
    tick();

    // start together with pc_load 0x20.
    pc_load = 1'b1; pc_load_val = 8'h20; start = 1'b1; tick();
    pc_load = 1'b0; start = 1'b0;
    tick(); tick(); tick();
    chk("f3_done", 64'(done_b), 64'h1);
    tick();
    chk("f3_ir", 64'(ir_b), 64'h030201);
    chk("f3_pc", 64'(pc_b), 64'h23);
    chk("f3a_ir", 64'(ir_a), 64'h0201);
    tick();

`ifdef IR_FETCH_ABORT_EN
    // Abort in the second READ cycle of a fetch from 0x10.
    pc_load = 1'b1; pc_load_val = 8'h10; tick(); pc_load = 1'b0;
    ir_op(2'b00, 2'd0, 8'h00);
    ir_op(2'b01, 2'd1, 8'h77);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_pulse", 64'(aborted_a), 64'h1);
    chk("ab_ir", 64'(ir_a), 64'h77A5);
    chk("ab_pc", 64'(pc_a), 64'h11);
    chk("ab_done", 64'(done_a), 64'h0);
    chk("abb_ir", 64'(ir_b), 64'h0077A5);
    tick();
    chk("ab_pulse_end", 64'(aborted_a), 64'h0);
    tick();
`endif

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
